eeprom_req_arbiter: RTL and testbench
=====================================

Name: eeprom_req_arbiter

Overview:
- Shares the single serial EEPROM read/write master among N independent requesters.
- Round-robin arbitration; one byte transaction in flight at a time.
- Drives the master's WR/RD strobes, 11-bit address and write byte, then waits for its one-cycle ACK.
- Returns the read byte and a per-requester done pulse. Sits between system agents and the EEPROM master, on the same CLK.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 11, EEPROM byte address width
- DATA_W, 8, data byte width
- TIMEOUT_CYC, 4096, WAIT-state cycle limit (used only with the optional feature)

Ports:
- CLK  in  1  clock
- RESET  in  1  reset
- req  in  N_REQ  per-requester transaction request, level
- req_rnw  in  N_REQ  1=read, 0=write, per requester
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  packed write bytes
- gnt  out  N_REQ  one-hot, owner of current transaction
- done  out  N_REQ  one-cycle completion pulse to owner
- rdata  out  DATA_W  read byte, valid in done cycle, held until next done
- err  out  1  timeout flag, pulses with done
- busy  out  1  transaction in progress
- eep_wr  out  1  write strobe to master
- eep_rd  out  1  read strobe to master
- eep_addr  out  ADDR_W  address to master
- eep_wdata  out  DATA_W  write byte to master
- eep_rdata  in  DATA_W  byte from master's data bus
- eep_ack  in  1  master completion pulse

Behaviour:
- Reset and clock: reset RESET, synchronous, active-high; clock CLK. All logic is on posedge CLK.
- Reset values: gnt=0, done=0, rdata=0, err=0, busy=0, eep_wr=0, eep_rd=0, eep_addr=0, eep_wdata=0, state=IDLE, last_grant=N_REQ-1.
- State IDLE:
  - If any req bit is high, pick the first requester at or after last_grant+1 (mod N_REQ).
  - Register gnt, eep_addr, eep_wdata and the rnw bit from that requester; set busy=1; go to ISSUE.
  - If no req bit is high, stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - Assert eep_rd if rnw=1, else eep_wr.
  - Set last_grant to the granted index; go to WAIT.
  - eep_wr/eep_rd are never high for more than one cycle, because the master re-triggers on a held strobe.
- State WAIT:
  - eep_addr and eep_wdata stay frozen.
  - When eep_ack=1, capture eep_rdata into rdata (reads only; writes leave rdata unchanged) and go to DONE.
- State DONE (1 cycle):
  - done[owner]=1, gnt cleared, busy=0; go to IDLE.
  - The master has already returned to its Idle state, so a new ISSUE can follow 2 cycles later at the earliest.
- Latency: req high in cycle t gives eep strobe in t+1. done = cycle after ack + 0; it occurs in the cycle following eep_ack.
- Requester rules:
  - req_* fields are sampled only in IDLE. Later changes are ignored.
  - If req drops mid-transaction, the transaction still completes and done still pulses.
  - If req is still high in the IDLE after its done, it is a new request.
- Simultaneous requests: rotation is strict, and no requester gets two consecutive grants while another is waiting.
- eep_ack outside WAIT is ignored.
- Reset mid-transaction: return to the reset values immediately. The EEPROM master shares RESET and aborts too; no done is issued.

Optional Feature:
- EEPROM_ARB_TIMEOUT_EN defined:
  - A cycle counter, cleared on entering WAIT.
  - If it reaches TIMEOUT_CYC without eep_ack, go to DONE with err=1 and rdata=8'hFF.
  - The master is not reset by the arbiter.
- Not defined: no counter; err is tied to 0 and WAIT lasts indefinitely.

Decomposition:
- Package eeprom_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE)
  - ADDR_W/DATA_W defaults
  - the 8'hFF timeout fill constant
- One natural sub-module, eeprom_rr_picker: combinational, takes req and last_grant, outputs a one-hot pick and its index.

Test Plan:
- Single write: req[1]=1, rnw=0, addr=11'h2A5, wdata=8'h3C → eep_wr one cycle, eep_addr=11'h2A5, eep_wdata=8'h3C, done[1] the cycle after eep_ack, err=0.
- Single read: req[2] read of 11'h010, model returns 8'h5A with ack → rdata=8'h5A in done[2] cycle, held afterwards.
- Contention: req=4'b1111 held after reset → grant order 0,1,2,3,0; exactly one strobe per transaction; gnt always one-hot.
- Requester drops req[0] during WAIT → transaction still finishes and done[0] pulses; no re-grant to 0 unless req[0] is reasserted.
- Timeout (macro on, TIMEOUT_CYC=16): model never acks → done and err pulse after 16 WAIT cycles, rdata=8'hFF. With the macro off, the bench holds in WAIT for 1000 cycles.
- RESET asserted in WAIT → next cycle all outputs at reset values; next arbitration starts at requester 0.

Source files
------------

// File: rtl/eeprom_arb_pkg.sv
// Shared types and constants for the EEPROM request arbiter.
package eeprom_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDone
   } state_e;

   localparam int unsigned ADDR_W_DEF = 11;
   localparam int unsigned DATA_W_DEF = 8;

   // Read data returned to the owner when the master never acknowledges.
   localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

endpackage

// File: rtl/eeprom_req_arbiter_if.sv
// Requester-side and EEPROM-master-side signals of the arbiter.
// master: the arbiter's view; slave: the agents and EEPROM master seen together.
interface eeprom_req_arbiter_if
   import eeprom_arb_pkg::*;
#(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        req_rnw;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        done;
   logic [DATA_W-1:0]       rdata;
   logic                    err;
   logic                    busy;

   logic                    eep_wr;
   logic                    eep_rd;
   logic [ADDR_W-1:0]       eep_addr;
   logic [DATA_W-1:0]       eep_wdata;
   logic [DATA_W-1:0]       eep_rdata;
   logic                    eep_ack;

   modport master (
      input  req, req_rnw, req_addr, req_wdata, eep_rdata, eep_ack,
      output gnt, done, rdata, err, busy, eep_wr, eep_rd, eep_addr, eep_wdata
   );

   modport slave (
      output req, req_rnw, req_addr, req_wdata, eep_rdata, eep_ack,
      input  gnt, done, rdata, err, busy, eep_wr, eep_rd, eep_addr, eep_wdata
   );

endinterface

// File: rtl/eeprom_rr_picker.sv
// Round-robin pick: first requester strictly after last_grant, wrapping mod N_REQ.
module eeprom_rr_picker #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N_REQ-1:0] pick,
   output logic [IDX_W-1:0] pick_idx,
   output logic             pick_valid
);

   always_comb begin
      int unsigned      cand;
      logic [IDX_W-1:0] cidx;
      cand       = 0;
      cidx       = '0;
      pick       = '0;
      pick_idx   = '0;
      pick_valid = 1'b0;
      // Offset N_REQ lands back on last_grant itself, so it is considered last.
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         cand = (32'(last_grant) + off) % N_REQ;
         cidx = IDX_W'(cand);
         if (!pick_valid && req[cidx]) begin
            pick[cidx] = 1'b1;
            pick_idx   = cidx;
            pick_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eeprom_req_arbiter.sv
// Round-robin arbiter sharing one serial EEPROM byte master among N_REQ requesters.
// Optional WAIT timeout enabled by defining EEPROM_ARB_TIMEOUT_EN.
module eeprom_req_arbiter
   import eeprom_arb_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input logic                 CLK,
   input logic                 RESET,
   eeprom_req_arbiter_if.master bus
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC == 0) begin : g_bad_cfg
      $error("eeprom_req_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC nonzero");
   end

   state_e           state_q;
   logic [IDX_W-1:0] last_grant_q;
   logic [IDX_W-1:0] owner_q;
   logic             rnw_q;

   logic [N_REQ-1:0] pick;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;

   eeprom_rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req        (bus.req),
      .last_grant (last_grant_q),
      .pick       (pick),
      .pick_idx   (pick_idx),
      .pick_valid (pick_valid)
   );

`ifdef EEPROM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wait_cnt_q;
   logic             timeout;
   // Fires on the last permitted WAIT cycle, so WAIT lasts exactly TIMEOUT_CYC cycles.
   assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

   // All outputs are registered; a value set on a transition is visible in the state entered.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= StIdle;
         last_grant_q  <= IDX_W'(N_REQ - 1);
         owner_q       <= '0;
         rnw_q         <= 1'b0;
         bus.gnt       <= '0;
         bus.done      <= '0;
         bus.rdata     <= '0;
         bus.err       <= 1'b0;
         bus.busy      <= 1'b0;
         bus.eep_wr    <= 1'b0;
         bus.eep_rd    <= 1'b0;
         bus.eep_addr  <= '0;
         bus.eep_wdata <= '0;
`ifdef EEPROM_ARB_TIMEOUT_EN
         wait_cnt_q    <= '0;
`endif
      end else begin
         bus.done   <= '0;
         bus.err    <= 1'b0;
         bus.eep_wr <= 1'b0;
         bus.eep_rd <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  bus.gnt       <= pick;
                  owner_q       <= pick_idx;
                  rnw_q         <= bus.req_rnw[pick_idx];
                  bus.eep_addr  <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
                  bus.eep_wdata <= bus.req_wdata[pick_idx*DATA_W +: DATA_W];
                  // Strobe is high only for the single ISSUE cycle; the master
                  // would re-trigger on a held strobe.
                  bus.eep_rd    <= bus.req_rnw[pick_idx];
                  bus.eep_wr    <= ~bus.req_rnw[pick_idx];
                  bus.busy      <= 1'b1;
                  state_q       <= StIssue;
               end
            end
            StIssue: begin
               last_grant_q <= owner_q;
               state_q      <= StWait;
`ifdef EEPROM_ARB_TIMEOUT_EN
               wait_cnt_q   <= '0;
`endif
            end
            StWait: begin
               if (bus.eep_ack) begin
                  if (rnw_q) begin
                     bus.rdata <= bus.eep_rdata;
                  end
                  bus.done <= bus.gnt;
                  bus.gnt  <= '0;
                  bus.busy <= 1'b0;
                  state_q  <= StDone;
`ifdef EEPROM_ARB_TIMEOUT_EN
               end else if (timeout) begin
                  bus.rdata <= DATA_W'(TIMEOUT_FILL);
                  bus.err   <= 1'b1;
                  bus.done  <= bus.gnt;
                  bus.gnt   <= '0;
                  bus.busy  <= 1'b0;
                  state_q   <= StDone;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eeprom_req_arbiter.sv
// Directed self-checking bench for eeprom_req_arbiter; EEPROM master modelled inline.
module tb_eeprom_req_arbiter;

   localparam int unsigned N_REQ       = 4;
   localparam int unsigned ADDR_W      = 11;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned TIMEOUT_CYC = 16;

   logic CLK = 1'b0;
   logic RESET = 1'b1;

   always #5 CLK = ~CLK;

   eeprom_req_arbiter_if #(
      .N_REQ  (N_REQ),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) bus ();

   eeprom_req_arbiter #(
      .N_REQ       (N_REQ),
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errs   = 0;
   logic [7:0]  exp_rdata = 8'h00;

   logic [10:0] tab_addr  [4] = '{11'h100, 11'h101, 11'h102, 11'h103};
   logic [7:0]  tab_wdata [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
   logic        tab_rnw   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   int          seq_own   [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 1};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_fields(input int i, input logic rnw, input logic [10:0] addr,
                             input logic [7:0] wd);
      bus.req_rnw[i]                  = rnw;
      bus.req_addr[i*ADDR_W +: ADDR_W] = addr;
      bus.req_wdata[i*DATA_W +: DATA_W] = wd;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_gnt"},   32'(bus.gnt), 0);
      check({tag, "_done"},  32'(bus.done), 0);
      check({tag, "_rdata"}, 32'(bus.rdata), 0);
      check({tag, "_flags"}, {28'h0, bus.err, bus.busy, bus.eep_wr, bus.eep_rd}, 0);
      check({tag, "_addr"},  32'(bus.eep_addr), 0);
      check({tag, "_wdata"}, 32'(bus.eep_wdata), 0);
   endtask

   // Entered with the DUT in its ISSUE cycle; returns in the IDLE cycle after DONE.
   task automatic do_txn(input int own, input logic rnw, input logic [10:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd, input int lat,
                         input logic [3:0] drop);
      logic [3:0] oh;
      oh = 4'(1 << own);
      check($sformatf("issue_gnt%0d", own), 32'(bus.gnt), 32'(oh));
      check("issue_busy", 32'(bus.busy), 1);
      check("issue_strobe", {30'h0, bus.eep_wr, bus.eep_rd}, rnw ? 32'h1 : 32'h2);
      check("issue_addr", 32'(bus.eep_addr), 32'(addr));
      check("issue_wdata", 32'(bus.eep_wdata), 32'(wd));
      tick();
      bus.req = bus.req & ~drop;
      check("wait_first", {25'h0, bus.eep_wr, bus.eep_rd, bus.done, bus.busy},
            32'h1);
      for (int k = 0; k < lat; k++) begin
         tick();
         check("wait_hold", {25'h0, bus.eep_wr, bus.eep_rd, bus.done, bus.busy,
               bus.eep_addr == addr}, 32'h3);
      end
      bus.eep_ack   = 1'b1;
      bus.eep_rdata = rd;
      tick();
      bus.eep_ack   = 1'b0;
      bus.eep_rdata = 8'h00;
      if (rnw) exp_rdata = rd;
      check($sformatf("done%0d", own), 32'(bus.done), 32'(oh));
      check("done_gnt_busy", {27'h0, bus.gnt, bus.busy}, 0);
      check("done_err", 32'(bus.err), 0);
      check("done_rdata", 32'(bus.rdata), 32'(exp_rdata));
      tick();
      check("done_clear", {27'h0, bus.done, bus.eep_wr}, 0);
   endtask

   initial begin
      int bad;
      bus.req       = '0;
      bus.req_rnw   = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.eep_ack   = 1'b0;
      bus.eep_rdata = '0;

      tick();
      tick();
      check_reset_outs("reset");
      RESET = 1'b0;
      tick();
      check_reset_outs("idle");

      // Single write from requester 1.
      set_fields(1, 1'b0, 11'h2A5, 8'h3C);
      bus.req = 4'b0010;
      tick();
      bus.req = 4'b0000;
      do_txn(1, 1'b0, 11'h2A5, 8'h3C, 8'hEE, 2, 4'b0000);

      // Single read from requester 2, then rdata held and stray ack ignored.
      set_fields(2, 1'b1, 11'h010, 8'h99);
      bus.req = 4'b0100;
      tick();
      bus.req = 4'b0000;
      do_txn(2, 1'b1, 11'h010, 8'h99, 8'h5A, 1, 4'b0000);
      tick();
      tick();
      check("rdata_held", 32'(bus.rdata), 32'h5A);
      bus.eep_ack   = 1'b1;
      bus.eep_rdata = 8'h77;
      tick();
      bus.eep_ack   = 1'b0;
      tick();
      check("stray_ack", {19'h0, bus.done, bus.busy, bus.rdata}, 32'h5A);

      // Contention from reset; req[0] drops during its second WAIT.
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      exp_rdata = 8'h00;
      for (int i = 0; i < 4; i++) set_fields(i, tab_rnw[i], tab_addr[i], tab_wdata[i]);
      bus.req = 4'b1111;
      tick();
      for (int n = 0; n < 9; n++) begin
         do_txn(seq_own[n], tab_rnw[seq_own[n]], tab_addr[seq_own[n]],
                tab_wdata[seq_own[n]], 8'(8'h40 + n), n % 3,
                (n == 4) ? 4'b0001 : 4'b0000);
         if (n == 8) bus.req = 4'b0000;
         tick();
      end
      check("contention_end", {27'h0, bus.gnt, bus.busy}, 0);

      // Never-acknowledged read from requester 2.
      set_fields(2, 1'b1, 11'h7FF, 8'h11);
      bus.req = 4'b0100;
      tick();
      bus.req = 4'b0000;
      check("to_issue", {27'h0, bus.gnt, bus.eep_rd}, 32'h9);
`ifdef EEPROM_ARB_TIMEOUT_EN
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (bus.done != 4'b0000 || bus.busy != 1'b1 || bus.err != 1'b0) bad++;
      end
      check("to_wait16", 32'(bad), 0);
      tick();
      check("to_done", 32'(bus.done), 32'h4);
      check("to_err", 32'(bus.err), 1);
      check("to_rdata", 32'(bus.rdata), 32'hFF);
      tick();
      check("to_err_clear", {28'h0, bus.err, bus.done[2], bus.busy, 1'b0}, 0);
      bus.req = 4'b0100;
      tick();
      bus.req = 4'b0000;
      tick();
      tick();
`else
      bad = 0;
      for (int k = 0; k < 1000; k++) begin
         tick();
         if (bus.done != 4'b0000 || bus.busy != 1'b1 || bus.err != 1'b0) bad++;
      end
      check("hold_1000", 32'(bad), 0);
`endif
      check("pre_reset_busy", {27'h0, bus.gnt, bus.busy}, 32'h9);

      // Reset in WAIT, then arbitration restarts at requester 0.
      RESET = 1'b1;
      tick();
      check_reset_outs("midreset");
      RESET = 1'b0;
      exp_rdata = 8'h00;
      for (int i = 0; i < 4; i++) set_fields(i, tab_rnw[i], tab_addr[i], tab_wdata[i]);
      bus.req = 4'b1001;
      tick();
      bus.req = 4'b0000;
      do_txn(0, 1'b0, 11'h100, 8'hA0, 8'h33, 0, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
